// File: rtl/dmem_access_ctrl_if.sv
// Bundle of execute-stage request, memory-stage response and data-memory
// handshake signals seen by dmem_access_ctrl.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] addr;
  logic [15:0] writedata;
  logic        halt;
  logic        stall;
  logic        done;
  logic [15:0] readData;
  logic        err;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_createdump;
  logic        mem_busy;
  logic        mem_done;
  logic [15:0] mem_data_out;

  // Controller view
  modport slave (
    input  req_valid, MemRead, MemWrite, addr, writedata, halt,
           mem_busy, mem_done, mem_data_out,
    output stall, done, readData, err,
           mem_enable, mem_wr, mem_addr, mem_data_in, mem_createdump
  );

  // Pipeline plus memory view
  modport master (
    output req_valid, MemRead, MemWrite, addr, writedata, halt,
           mem_busy, mem_done, mem_data_out,
    input  stall, done, readData, err,
           mem_enable, mem_wr, mem_addr, mem_data_in, mem_createdump
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory access controller: latches one load/store, issues
// it with a busy/done handshake, stalls the pipeline until completion,
// flags unaligned accesses and sequences the halt-time memory dump.
// Optional feature macro: DMEM_TIMEOUT_EN (abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without mem_done, reporting err).
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input logic              clk,
  input logic              rst,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    HALTED
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q;
  logic        err_q;
  logic        dumped_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] read_q;

  logic        req_mem;
  logic        accept;
  logic        unaligned;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES == 0 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
    $error("dmem_access_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  assign req_mem   = bus.req_valid & (bus.MemRead | bus.MemWrite);
  assign accept    = (state_q == IDLE) & req_mem & ~bus.addr[0];
  assign unaligned = (state_q == IDLE) & req_mem &  bus.addr[0];

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;

  // Abort on the WAIT cycle whose increment would bring the count to TIMEOUT_CYCLES
  assign timeout_hit = (state_q == WAIT) & ~bus.mem_done &
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared when the memory accepts, saturating count of idle WAIT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE && !bus.mem_busy) begin
      cnt_q <= '0;
    end else if (state_q == WAIT && !bus.mem_done && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_d            = state_q;
    bus.stall          = accept;
    bus.done           = 1'b0;
    bus.err            = 1'b0;
    bus.mem_enable     = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_addr       = addr_q;
    bus.mem_data_in    = data_q;
    bus.mem_createdump = 1'b0;
    bus.readData       = read_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
        end else if (unaligned) begin
          state_d = RESP;
        end else if (bus.halt) begin
          state_d = HALTED;
        end
      end
      ISSUE: begin
        bus.stall      = 1'b1;
        bus.mem_enable = 1'b1;
        bus.mem_wr     = wr_q;
        if (!bus.mem_busy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        bus.stall = 1'b1;
        if (bus.mem_done || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        state_d  = bus.halt ? HALTED : IDLE;
      end
      HALTED: begin
        bus.mem_createdump = ~dumped_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, error flag, load data capture and one-shot dump tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      dumped_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      read_q   <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.addr;
        data_q <= bus.writedata;
        wr_q   <= bus.MemWrite;
        err_q  <= 1'b0;
      end
      if (unaligned || timeout_hit) begin
        err_q <= 1'b1;
      end
      if (state_q == WAIT && bus.mem_done && !wr_q) begin
        read_q <= bus.mem_data_out;
      end
      dumped_q <= (state_q == HALTED);
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: IDLE-decode vector table,
// directed multi-cycle sequences and randomized transactions checked
// against a transaction-level latency/data model.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES(15),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_rd;

  typedef struct {
    logic        rv;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        e_stall;
    logic        e_en;
    logic        e_wr;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.addr         = '0;
    bus.writedata    = '0;
    bus.halt         = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.mem_done     = 1'b0;
    bus.mem_data_out = '0;
  endtask

  task automatic clear_req();
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stall"},      bus.stall, 0);
    chk({tag, "_done"},       bus.done, 0);
    chk({tag, "_err"},        bus.err, 0);
    chk({tag, "_readData"},   bus.readData, 0);
    chk({tag, "_mem_enable"}, bus.mem_enable, 0);
    chk({tag, "_mem_wr"},     bus.mem_wr, 0);
    chk({tag, "_mem_addr"},   bus.mem_addr, 0);
    chk({tag, "_mem_data"},   bus.mem_data_in, 0);
    chk({tag, "_dump"},       bus.mem_createdump, 0);
  endtask

  // Leaves the bench at posedge+1 with the DUT in IDLE
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    smp();
    chk_reset(tag);
    rst = 1'b0;
    exp_rd = '0;
    tick();
  endtask

  // Reference model of one transaction issued from IDLE: aligned accesses
  // complete 3 + busy + wait cycles after accept; unaligned ones respond
  // with done+err on the next cycle and never touch memory.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd,
                         input int unsigned nb, input int unsigned nw,
                         input logic [15:0] rdata, input logic hlt);
    logic        aligned;
    int unsigned lat;
    int unsigned kdone;
    aligned = ~a[0];
    lat     = 3 + nb + nw;
    kdone   = nb + 2 + nw;
    bus.req_valid = 1'b1;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.addr      = a;
    bus.writedata = wd;
    bus.halt      = hlt;
    bus.mem_busy  = 1'b0;
    bus.mem_done  = 1'b0;
    smp();
    chk({tag, "_accept_stall"}, bus.stall, aligned);
    chk({tag, "_accept_done"},  bus.done, 0);
    tick();
    clear_req();
    bus.addr = 16'($urandom);
    if (!aligned) begin
      smp();
      chk({tag, "_unal_done"},  bus.done, 1);
      chk({tag, "_unal_err"},   bus.err, 1);
      chk({tag, "_unal_stall"}, bus.stall, 0);
      chk({tag, "_unal_en"},    bus.mem_enable, 0);
      chk({tag, "_unal_rdata"}, bus.readData, exp_rd);
      tick();
      return;
    end
    for (int unsigned k = 1; k <= lat; k++) begin
      if (k <= nb)          bus.mem_busy = 1'b1;
      else if (k == nb + 1) bus.mem_busy = 1'b0;
      else                  bus.mem_busy = 1'($urandom);
      if (k <= nb + 1 || k == lat) bus.mem_done = 1'($urandom);
      else                         bus.mem_done = (k == kdone);
      bus.mem_data_out = (k == kdone) ? rdata : 16'($urandom);
      if (k == kdone && !wr) exp_rd = rdata;
      smp();
      chk({tag, "_en"}, bus.mem_enable, (k <= nb + 1));
      if (k <= nb + 1) begin
        chk({tag, "_mem_wr"},   bus.mem_wr, wr);
        chk({tag, "_mem_addr"}, bus.mem_addr, a);
        chk({tag, "_mem_data"}, bus.mem_data_in, wd);
      end
      chk({tag, "_stall"}, bus.stall, (k < lat));
      chk({tag, "_done"},  bus.done, (k == lat));
      if (k == lat) begin
        chk({tag, "_err"},   bus.err, 0);
        chk({tag, "_rdata"}, bus.readData, exp_rd);
      end
      tick();
    end
    bus.mem_busy = 1'b0;
    bus.mem_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        got_done;
    logic [15:0] ra;
    logic        rrd, rwr;
    int unsigned sel;

    //            rv    rd    wr    addr      wdata     stall en    wr    done  err
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0100, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    do_reset("reset");

    // IDLE decode table
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = vecs[i].rv;
      bus.MemRead   = vecs[i].rd;
      bus.MemWrite  = vecs[i].wr;
      bus.addr      = vecs[i].addr;
      bus.writedata = vecs[i].wdata;
      smp();
      chk($sformatf("vec%0d_stall", i), bus.stall, vecs[i].e_stall);
      tick();
      clear_req();
      smp();
      chk($sformatf("vec%0d_en", i),   bus.mem_enable, vecs[i].e_en);
      chk($sformatf("vec%0d_wr", i),   bus.mem_wr, vecs[i].e_wr);
      chk($sformatf("vec%0d_done", i), bus.done, vecs[i].e_done);
      chk($sformatf("vec%0d_err", i),  bus.err, vecs[i].e_err);
      if (vecs[i].e_en) begin
        chk($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].addr);
        chk($sformatf("vec%0d_data", i), bus.mem_data_in, vecs[i].wdata);
        bus.mem_done     = 1'b1;
        bus.mem_data_out = 16'hA5A0 + 16'(i);
        if (!vecs[i].wr) exp_rd = 16'hA5A0 + 16'(i);
        got_done = 1'b0;
        for (int n = 0; n < 6 && !got_done; n++) begin
          tick();
          smp();
          got_done = bus.done;
        end
        chk($sformatf("vec%0d_drain_done", i), got_done, 1);
        chk($sformatf("vec%0d_rdata", i), bus.readData, exp_rd);
        bus.mem_done = 1'b0;
      end
      tick();
    end

    // Test-plan load and store-with-busy
    run_txn("load_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 1'b0);
    chk("load_beef_final", bus.readData, 16'hBEEF);
    run_txn("store_busy", 1'b0, 1'b1, 16'h0020, 16'h1234, 2, 0, 16'h3333, 1'b0);
    run_txn("rw_both", 1'b1, 1'b1, 16'h0042, 16'h7E7E, 1, 2, 16'h4444, 1'b0);
    run_txn("unaligned", 1'b1, 1'b0, 16'h0011, 16'h0000, 0, 0, 16'h0000, 1'b0);

    // Memory never completes
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b1;
    bus.addr      = 16'h0040;
    smp();
    chk("tmo_accept_stall", bus.stall, 1);
    tick();
    clear_req();
`ifdef DMEM_TIMEOUT_EN
    for (int unsigned k = 1; k <= 17; k++) begin
      smp();
      chk("tmo_stall", bus.stall, (k < 17));
      chk("tmo_done",  bus.done, (k == 17));
      if (k == 17) begin
        chk("tmo_err",   bus.err, 1);
        chk("tmo_rdata", bus.readData, exp_rd);
      end
      tick();
    end
`else
    for (int unsigned k = 1; k <= 40; k++) begin
      smp();
      chk("hang_stall", bus.stall, 1);
      chk("hang_done",  bus.done, 0);
      tick();
    end
    do_reset("hang_reset");
`endif

    // Reset during WAIT abandons the access
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b1;
    bus.addr      = 16'h0050;
    smp();
    tick();
    clear_req();
    smp();
    chk("rstw_issue_en", bus.mem_enable, 1);
    tick();
    smp();
    chk("rstw_wait_stall", bus.stall, 1);
    tick();
    rst = 1'b1;
    tick();
    smp();
    chk_reset("rstw");
    rst = 1'b0;
    exp_rd = '0;
    bus.mem_done     = 1'b1;
    bus.mem_data_out = 16'h7777;
    for (int n = 0; n < 3; n++) begin
      tick();
      smp();
      chk("rstw_stale_done",  bus.done, 0);
      chk("rstw_stale_rdata", bus.readData, 0);
    end
    bus.mem_done = 1'b0;
    tick();

    // Randomized transactions against the model
    for (int t = 0; t < 60; t++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.req_valid = 1'($urandom);
        bus.mem_done  = 1'($urandom);
        bus.mem_busy  = 1'($urandom);
        smp();
        chk("rnd_gap_stall", bus.stall, 0);
        chk("rnd_gap_done",  bus.done, 0);
        tick();
      end
      clear_req();
      bus.mem_done = 1'b0;
      bus.mem_busy = 1'b0;
      sel = $urandom_range(0, 2);
      rrd = (sel != 1);
      rwr = (sel != 0);
      ra  = 16'($urandom);
      ra[0] = ($urandom_range(0, 3) == 0);
      run_txn("rnd", rrd, rwr, ra, 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 4), 16'($urandom), 1'b0);
    end

    // Halt together with a request: request first, then one dump pulse
    do_reset("halt_rst1");
    run_txn("halt_req", 1'b1, 1'b0, 16'h0030, 16'h0000, 0, 1, 16'h4242, 1'b1);
    smp();
    chk("halt_req_dump1", bus.mem_createdump, 1);
    chk("halt_req_stall", bus.stall, 0);
    tick();
    bus.halt      = 1'b0;
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b1;
    bus.addr      = 16'h0060;
    for (int n = 0; n < 4; n++) begin
      smp();
      chk("halted_dump",  bus.mem_createdump, 0);
      chk("halted_stall", bus.stall, 0);
      chk("halted_en",    bus.mem_enable, 0);
      chk("halted_done",  bus.done, 0);
      chk("halted_rdata", bus.readData, 16'h4242);
      tick();
    end
    clear_req();

    // Halt alone in IDLE
    do_reset("halt_rst2");
    bus.halt = 1'b1;
    smp();
    chk("halt_idle_dump0", bus.mem_createdump, 0);
    tick();
    smp();
    chk("halt_idle_dump1", bus.mem_createdump, 1);
    tick();
    bus.req_valid = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.addr      = 16'h0070;
    smp();
    chk("halt_idle_dump2", bus.mem_createdump, 0);
    chk("halt_idle_stall", bus.stall, 0);
    tick();
    smp();
    chk("halt_idle_en", bus.mem_enable, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
